// File: rtl/air_quality_pkg.sv
// Shared constants for the air-quality scheduler: state encoding, default
// thresholds/timing and the sensor sample width.
package air_quality_pkg;
  localparam int SAMPLE_W            = 8;
  localparam int DEF_PUR_ON          = 100;
  localparam int DEF_PUR_OFF         = 80;
  localparam int DEF_HUM_ON          = 30;
  localparam int DEF_HUM_OFF         = 45;
  localparam int DEF_MIN_ON_CYCLES   = 16;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_CNT_W           = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PURIFY   = 2'd1,
    HUMIDIFY = 2'd2,
    COOLDOWN = 2'd3
  } aq_state_t;
endpackage

// File: rtl/aq_moving_average.sv
// 4-sample shift window; filt_avg is the truncated mean, combinational from
// the window registers so the FSM sees it one edge after capture.
module aq_moving_average
  import air_quality_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic [SAMPLE_W-1:0] filt_avg,
  output logic                avg_valid
);
  logic [3:0][SAMPLE_W-1:0] win;
  logic [2:0]               fill;
  logic [SAMPLE_W+1:0]      sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win  <= '0;
      fill <= '0;
    end else if (sample_valid) begin
      win <= {win[2:0], sample};
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) sum = sum + (SAMPLE_W+2)'(win[i]);
  end

  assign filt_avg  = sum[SAMPLE_W+1:2];
  assign avg_valid = (fill == 3'd4);
endmodule

// File: rtl/air_quality_scheduler.sv
// Purifier/humidifier sequencer: hysteresis thresholds on the filtered sample,
// minimum on-time, fixed cooldown, and mutually exclusive appliance drive.
module air_quality_scheduler
  import air_quality_pkg::*;
#(
  parameter int PUR_ON          = DEF_PUR_ON,
  parameter int PUR_OFF         = DEF_PUR_OFF,
  parameter int HUM_ON          = DEF_HUM_ON,
  parameter int HUM_OFF         = DEF_HUM_OFF,
  parameter int MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] air_quality,
  input  logic                sample_valid,
  input  logic                enable,
  output logic                purifier,
  output logic                humidifier,
  output logic [1:0]          state,
  output logic [SAMPLE_W-1:0] filt_avg,
  output logic                avg_valid
);
  localparam logic [SAMPLE_W-1:0] P_ON   = SAMPLE_W'(PUR_ON);
  localparam logic [SAMPLE_W-1:0] P_OFF  = SAMPLE_W'(PUR_OFF);
  localparam logic [SAMPLE_W-1:0] H_ON   = SAMPLE_W'(HUM_ON);
  localparam logic [SAMPLE_W-1:0] H_OFF  = SAMPLE_W'(HUM_OFF);
  localparam logic [CNT_W-1:0]    MIN_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]    COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

  aq_state_t        st, nxt;
  logic [CNT_W-1:0] cnt;

  aq_moving_average u_avg (
    .clk          (clk),
    .rst          (rst),
    .sample       (air_quality),
    .sample_valid (sample_valid),
    .filt_avg     (filt_avg),
    .avg_valid    (avg_valid)
  );

  // Purify wins when both requests could hold (cannot with legal thresholds).
  always_comb begin
    nxt = st;
    case (st)
      IDLE: begin
        if (enable && avg_valid) begin
          if (filt_avg >= P_ON)      nxt = PURIFY;
          else if (filt_avg <= H_ON) nxt = HUMIDIFY;
        end
      end
      PURIFY:
        if (!enable || (cnt >= MIN_LAST && filt_avg <= P_OFF)) nxt = COOLDOWN;
      HUMIDIFY:
        if (!enable || (cnt >= MIN_LAST && filt_avg >= H_OFF)) nxt = COOLDOWN;
      COOLDOWN:
        if (cnt == COOL_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Drives are registered from the next state so they track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      purifier   <= 1'b0;
      humidifier <= 1'b0;
    end else begin
      st         <= nxt;
      purifier   <= (nxt == PURIFY);
      humidifier <= (nxt == HUMIDIFY);
      if (nxt != st)     cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign state = st;
endmodule

// File: tb/tb_air_quality_scheduler.sv
// Directed bench: stimulus queues expected state transitions (with the length
// of the state being left); a monitor pops and checks them as the DUT moves.
module tb_air_quality_scheduler;
  import air_quality_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] air_quality = 8'd120;
  logic       sample_valid = 1'b0;
  logic       enable = 1'b0;
  logic       purifier, humidifier, avg_valid;
  logic [1:0] state;
  logic [7:0] filt_avg;

  int checks = 0, failures = 0, overlap = 0;

  typedef struct {logic [1:0] st; int dur;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [1:0] prev_st = 2'd0;
  int run = 0;

  air_quality_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .air_quality  (air_quality),
    .sample_valid (sample_valid),
    .enable       (enable),
    .purifier     (purifier),
    .humidifier   (humidifier),
    .state        (state),
    .filt_avg     (filt_avg),
    .avg_valid    (avg_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [1:0] s, input int d);
    q.push_back('{s, d});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    air_quality  = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Monitor: every state change must match the head of the expected queue.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_st = 2'd0;
      run     = 0;
    end else begin
      if (purifier && humidifier) overlap++;
      if (state != prev_st) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transition: got state %0d from %0d, expected no change", state, prev_st);
        end else begin
          e = q.pop_front();
          chk("tr_state", state, e.st);
          chk("tr_purifier", purifier, e.st == 2'd1);
          chk("tr_humidifier", humidifier, e.st == 2'd2);
          if (e.dur >= 0) chk("tr_prev_duration", run, e.dur);
        end
        prev_st = state;
        run     = 1;
      end else begin
        run++;
      end
    end
  end

  initial begin
    int n;
    // 1: reset with a live sample stream, then a partial window
    rst = 1'b1; enable = 1'b1; air_quality = 8'd120; sample_valid = 1'b1;
    tick(2);
    chk("rst_purifier", purifier, 0);
    chk("rst_humidifier", humidifier, 0);
    chk("rst_state", state, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_filt", filt_avg, 0);
    rst = 1'b0; sample_valid = 1'b0;
    repeat (3) send(8'd120);
    chk("partial_avg_valid", avg_valid, 0);
    chk("partial_filt", filt_avg, 90);
    tick(2);
    chk("partial_state", state, 0);

    // 2: window fills, purifier one edge later
    push_exp(2'd1, -1);
    send(8'd120);
    chk("full_filt", filt_avg, 120);
    chk("full_avg_valid", avg_valid, 1);
    chk("latency_state", state, 0);

    // 3: low samples right away -> exactly min-on, then exact cooldown
    push_exp(2'd3, 16);
    push_exp(2'd0, 8);
    send(8'd50);
    chk("purify_state", state, 1);
    chk("purify_purifier", purifier, 1);
    chk("purify_humidifier", humidifier, 0);
    repeat (3) send(8'd50);
    tick(30);
    chk("after_cool_state", state, 0);
    chk("after_cool_humidifier", humidifier, 0);
    chk("filt_50", filt_avg, 50);

    // 4: threshold boundaries
    send(8'd100); send(8'd100); send(8'd100); send(8'd99);
    chk("filt_99", filt_avg, 99);
    tick(3);
    chk("no_start_99", state, 0);
    push_exp(2'd1, -1);
    repeat (3) send(8'd100);
    chk("filt_still_99", filt_avg, 99);
    send(8'd100);
    chk("filt_100", filt_avg, 100);
    chk("pre_start_state", state, 0);
    tick(1);
    chk("start_100", state, 1);
    repeat (4) send(8'd81);
    chk("filt_81", filt_avg, 81);
    tick(25);
    chk("hold_81", state, 1);
    push_exp(2'd3, -1);
    push_exp(2'd0, 8);
    send(8'd80);
    chk("filt_80", filt_avg, 80);
    chk("pre_stop_state", state, 1);
    tick(1);
    chk("stop_80_state", state, 3);
    chk("stop_80_purifier", purifier, 0);
    tick(10);
    chk("idle_after_80", state, 0);

    // 5: humidify, then reversal through cooldown and idle
    push_exp(2'd2, -1);
    send(8'd20); send(8'd20); send(8'd20);
    chk("filt_35", filt_avg, 35);
    chk("no_hum_35", state, 0);
    send(8'd20);
    chk("filt_20", filt_avg, 20);
    push_exp(2'd3, 16);
    push_exp(2'd0, 8);
    push_exp(2'd1, 1);
    send(8'd120);
    chk("hum_state", state, 2);
    chk("hum_humidifier", humidifier, 1);
    repeat (3) send(8'd120);

    // 6: enable drop on PURIFY cycle 3, then async reset mid-cooldown
    n = 0;
    while (state != 2'd1 && n < 60) begin
      tick(1);
      n++;
    end
    chk("wait_purify", state, 1);
    tick(2);
    push_exp(2'd3, 3);
    enable = 1'b0;
    tick(1);
    chk("disable_state", state, 3);
    chk("disable_purifier", purifier, 0);
    tick(3);
    chk("mid_cool_state", state, 3);
    #1 rst = 1'b1;
    #1;
    chk("async_purifier", purifier, 0);
    chk("async_humidifier", humidifier, 0);
    chk("async_state", state, 0);
    chk("async_avg_valid", avg_valid, 0);
    chk("async_filt", filt_avg, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("queue_empty", q.size(), 0);
    chk("never_both_on", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/air_quality_scheduler.md
Name: air_quality_scheduler

Overview:
Sequences the home's purifier and humidifier from the 8-bit air-quality sensor stream. Smooths raw samples with a 4-sample moving average. Applies hysteresis thresholds, a minimum on-time and a mandatory cooldown. Arbitrates the single shared appliance power feed so that at most one appliance is on at a time.

Parameters:
PUR_ON, 100, filtered value at or above which purification is requested (inclusive)
PUR_OFF, 80, filtered value at or below which purification may stop (inclusive)
HUM_ON, 30, filtered value at or below which humidification is requested (inclusive)
HUM_OFF, 45, filtered value at or above which humidification may stop (inclusive)
MIN_ON_CYCLES, 16, minimum clk cycles an appliance stays on once started (≥1)
COOLDOWN_CYCLES, 8, exact clk cycles both appliances are off after any stop (≥1)
CNT_W, 16, width of the shared state-duration counter
Legal ordering: HUM_ON < HUM_OFF < PUR_OFF < PUR_ON.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
air_quality  in  8  raw sensor sample, unsigned
sample_valid  in  1  air_quality is accepted on a rising edge where this is high
enable  in  1  automatic control permitted; low forces shutdown
purifier  out  1  purifier drive, registered
humidifier  out  1  humidifier drive, registered
state  out  2  FSM state: IDLE=0, PURIFY=1, HUMIDIFY=2, COOLDOWN=3
filt_avg  out  8  current filtered value
avg_valid  out  1  high once 4 samples have been accepted since reset

Behaviour:
- Reset (asynchronous, immediate): purifier=0, humidifier=0, state=IDLE, window cleared, fill count=0, avg_valid=0, filt_avg=0, counter=0. Reset asserted in any state, including mid-PURIFY, drops outputs without waiting for a clk edge.
- Filter: on a clk edge with sample_valid=1, a 4-entry shift window takes the sample and the fill count saturates at 4. Sum is 10 bits. filt_avg = sum>>2, truncated (no rounding), and is combinational from the window registers. avg_valid = (fill==4).
- FSM evaluates filt_avg on every edge. Latency: the sample is captured at edge k, and the FSM/output change occurs at edge k+1.
- purifier = (state==PURIFY) and humidifier = (state==HUMIDIFY), both decoded from the state register. The two are never high together.
- Counter: cleared on every state change and incremented each cycle otherwise, saturating at all-ones.
- IDLE: if enable & avg_valid & filt_avg≥PUR_ON, go to PURIFY. Else if enable & avg_valid & filt_avg≤HUM_ON, go to HUMIDIFY. Purify has priority. Otherwise stay.
- PURIFY: if enable=0, go to COOLDOWN next edge; the min-on time is ignored. Else if cnt≥MIN_ON_CYCLES-1 and filt_avg≤PUR_OFF, go to COOLDOWN. A value in the hysteresis band keeps the purifier on indefinitely.
- HUMIDIFY: mirror of PURIFY, with exit condition filt_avg≥HUM_OFF.
- COOLDOWN: both outputs off. When cnt==COOLDOWN_CYCLES-1, go to IDLE, giving exactly COOLDOWN_CYCLES low cycles. There is no direct PURIFY↔HUMIDIFY transition; a reversal always passes through COOLDOWN and IDLE.
- An avg_valid=0 condition only occurs after reset, so the FSM is held in IDLE until the window fills.
- sample_valid is ignored for FSM purposes: the FSM uses whatever filt_avg is current.
- A sample arriving on the same edge as a state change is accepted normally. The FSM uses the pre-edge filt_avg.

Decomposition:
- Package air_quality_pkg: state encoding constants (IDLE/PURIFY/HUMIDIFY/COOLDOWN), default threshold and timing constants, and the 8-bit sample width.
- Sub-module aq_moving_average: window, fill count, sum, filt_avg and avg_valid.
- The FSM, counter and output decode live in the top module.

Test Plan:
1. Hold rst=1 with air_quality=120 and sample_valid=1 → outputs 0, state=0. Release rst and give 3 samples of 120 → avg_valid=0, state stays IDLE.
2. Four samples of 120 with enable=1 → filt_avg=120 after the 4th capture edge, purifier=1 on the following edge, humidifier=0, state=1.
3. In PURIFY, feed four samples of 50 immediately → purifier is high for exactly 16 cycles total, then low with state=3 for exactly 8 cycles, then state=0 and humidifier stays 0.
4. Threshold boundaries: window 100,100,100,99 → sum 399, filt_avg=99, no start. Replace one 99 with 100 → filt_avg=100, purifier starts. In PURIFY, filt_avg=81 after min-on → stays on; filt_avg=80 → stops.
5. Four samples of 20 → humidifier=1. Then four samples of 120 → humidifier off after min-on, 8 COOLDOWN cycles, then purifier=1. Assert purifier&humidifier is never 1 across the whole run.
6. Drop enable on cycle 3 of PURIFY → state=3 and purifier=0 on the next edge. Assert rst asynchronously mid-COOLDOWN → outputs 0 and avg_valid=0 before the next clk edge.
